pc_mem_unit: RTL

//   Parametrised program-counter and memory unit for the lab CPU: PC register with stall and

---
 rtl/pc_mem_unit_if.sv | 38 +++
 rtl/pc_mem_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc_mem_unit_if.sv
// Handshake/bus bundle between the control/next-PC logic and pc_mem_unit.
interface pc_mem_unit_if #(
    parameter int WIDTH = 32
);
    localparam int NB = WIDTH / 8;

    logic             Stall;
    logic             Branch;
    logic [WIDTH-1:0] Branch_PC;
    logic             Prog_we;
    logic [WIDTH-1:0] Prog_addr;
    logic [WIDTH-1:0] Prog_data;
    logic             S;
    logic             L;
    logic [NB-1:0]    Byte_en;
    logic [WIDTH-1:0] data_addr_in;
    logic [WIDTH-1:0] data_in;
    logic             Err_clr;
    logic [WIDTH-1:0] PC_out;
    logic [WIDTH-1:0] Iout;
    logic             I_valid;
    logic [WIDTH-1:0] Mout;
    logic             M_valid;
    logic             E;
    logic [1:0]       Err_code;

    modport master (
        output Stall, Branch, Branch_PC, Prog_we, Prog_addr, Prog_data,
        output S, L, Byte_en, data_addr_in, data_in, Err_clr,
        input  PC_out, Iout, I_valid, Mout, M_valid, E, Err_code
    );

    modport slave (
        input  Stall, Branch, Branch_PC, Prog_we, Prog_addr, Prog_data,
        input  S, L, Byte_en, data_addr_in, data_in, Err_clr,
        output PC_out, Iout, I_valid, Mout, M_valid, E, Err_code
    );
endinterface

// File: rtl/pc_mem_unit.sv
// PC register with stall/branch, registered fetch from loadable IMEM,
// byte-enabled DMEM with registered loads and sticky access-error flag.
module pc_mem_unit #(
    parameter int               WIDTH      = 32,
    parameter int               IMEM_DEPTH = 64,
    parameter int               DMEM_DEPTH = 64,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input logic           Clock,
    input logic           Reset_n,
    pc_mem_unit_if.slave  bus
);
    localparam int NB  = WIDTH / 8;
    localparam int AW  = $clog2(NB);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [WIDTH-1:0] imem_q [IMEM_DEPTH];
    logic [WIDTH-1:0] dmem_q [DMEM_DEPTH];

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] iout_q, mout_q;
    logic             ivalid_q, mvalid_q;
    logic             e_q, e_d;
    logic [1:0]       code_q, code_d;

    logic [IAW-1:0] fidx, pidx;
    logic [DAW-1:0] didx;
    logic           misal, oor, acc_ok, err, ld_ok, st_ok, fetch_en;
    logic           unused_bits;

    assign fidx     = pc_q[AW +: IAW];
    assign pidx     = bus.Prog_addr[AW +: IAW];
    assign didx     = bus.data_addr_in[AW +: DAW];
    assign misal    = |bus.data_addr_in[AW-1:0];
    assign oor      = |bus.data_addr_in[WIDTH-1:AW+DAW];
    assign acc_ok   = !misal && !oor;
    assign err      = (bus.S || bus.L) && !acc_ok;
    assign ld_ok    = bus.L && acc_ok;
    assign st_ok    = bus.S && acc_ok;
    assign fetch_en = !bus.Stall || bus.Branch;

    assign unused_bits = ^{bus.Prog_addr[AW-1:0], bus.Prog_addr[WIDTH-1:AW+IAW],
                           pc_q[AW-1:0], pc_q[WIDTH-1:AW+IAW]};

    always_comb begin
        pc_d = pc_q + WIDTH'(NB);
        if (bus.Branch)
            pc_d = bus.Branch_PC;
        else if (bus.Stall)
            pc_d = pc_q;
    end

    // A clear coinciding with a new error lets the new error start a fresh record.
    always_comb begin
        e_d    = e_q;
        code_d = code_q;
        if (err) begin
            e_d = 1'b1;
            if (!e_q || bus.Err_clr)
                code_d = {oor, misal};
        end else if (bus.Err_clr) begin
            e_d    = 1'b0;
            code_d = 2'b00;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q     <= RESET_PC;
            iout_q   <= '0;
            ivalid_q <= 1'b0;
            mout_q   <= '0;
            mvalid_q <= 1'b0;
            e_q      <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            pc_q     <= pc_d;
            e_q      <= e_d;
            code_q   <= code_d;
            mvalid_q <= ld_ok;
            if (fetch_en) begin
                iout_q   <= imem_q[fidx];
                ivalid_q <= !bus.Branch;
            end
            if (ld_ok)
                mout_q <= dmem_q[didx];
        end
    end

    always_ff @(posedge Clock) begin
        if (bus.Prog_we)
            imem_q[pidx] <= bus.Prog_data;
    end

    always_ff @(posedge Clock) begin
        for (int b = 0; b < NB; b++) begin
            if (st_ok && bus.Byte_en[b])
                dmem_q[didx][8*b +: 8] <= bus.data_in[8*b +: 8];
        end
    end

    assign bus.PC_out   = pc_q;
    assign bus.Iout     = iout_q;
    assign bus.I_valid  = ivalid_q;
    assign bus.Mout     = mout_q;
    assign bus.M_valid  = mvalid_q;
    assign bus.E        = e_q;
    assign bus.Err_code = code_q;
endmodule
